// File: rtl/mean_filter_pkg.sv
// Shared constants and helpers for the 3x3 mean filter.
// The mean is a fixed-point multiply by 7282/65536, which is close to 1/9.
package mean_filter_pkg;

   localparam int MEAN_RECIP = 7282;
   localparam int MEAN_SHIFT = 16;
   localparam int MEAN_RND   = 32768;

   // Nine DW-bit pixels need four extra bits.
   function automatic int mean_sum_w(input int dw);
      return dw + 4;
   endfunction

   typedef struct packed {
      logic vld;
      logic vsync;
      logic mask;
   } ctl_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixels in a single-port RAM with a registered read, 1-cycle read latency.
// Read-before-write: the old contents at the address appear on rdat_o while the new pixel is stored. No backpressure.
module line_buffer #(
   parameter int DW = 8,
   parameter int IW = 640
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [$clog2(IW)-1:0] addr_i,
   input  logic [DW-1:0]         wdat_i,
   output logic [DW-1:0]         rdat_o
);

   logic [DW-1:0] mem_q [IW];
   logic [DW-1:0] rdat_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         rdat_q         <= mem_q[addr_i];
         mem_q[addr_i]  <= wdat_i;
      end
   end

   assign rdat_o = rdat_q;

endmodule

// File: rtl/mean_filter_3x3.sv
// Streaming 3x3 box filter. Fixed 3-cycle latency, one pixel per cycle, no backpressure.
// Defining MEAN_FILTER_ROUND_EN rounds the mean to nearest; by default the mean is truncated.
module mean_filter_3x3
   import mean_filter_pkg::*;
#(
   parameter int DW = 8,
   parameter int IW = 640,
   parameter int IH = 512
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_vsync,
   input  logic          in_dvalid,
   input  logic [DW-1:0] in_data,
   output logic          out_vsync,
   output logic          out_dvalid,
   output logic [DW-1:0] out_data
);

   localparam int SW = mean_sum_w(DW);
   localparam int PW = SW + 14;
   localparam int AW = $clog2(IW);
   localparam int RW = $clog2(IH + 1);
`ifdef MEAN_FILTER_ROUND_EN
   localparam logic [PW-1:0] RND = PW'(MEAN_RND);
`else
   localparam logic [PW-1:0] RND = '0;
`endif

   logic [AW-1:0]        col_q, col_d, s1_col_q;
   logic [RW-1:0]        row_q, row_d;
   logic                 wr_en, s1_en_q, s2_en_q;
   ctl_t                 s1_d, s1_q, s2_q;
   logic [DW-1:0]        s1_pix_q, buf0_rd, buf1_rd;
   logic [1:0][DW-1:0]   top_q, mid_q, bot_q;
   logic [SW-1:0]        part_d, s2_part_q, sum_d;
   logic [DW-1:0]        out_data_d, out_data_q;
   logic                 out_vsync_q, out_dvalid_q;

   // A pixel that arrives during vsync still flows to the output but never touches counters, RAMs or window.
   assign wr_en = in_dvalid & ~in_vsync;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (in_vsync) begin
         col_d = '0;
         row_d = '0;
      end else if (in_dvalid) begin
         if (col_q == AW'(IW - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IH)) ? row_q : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      s1_d       = '0;
      s1_d.vld   = in_dvalid;
      s1_d.vsync = in_vsync;
      s1_d.mask  = in_vsync | (col_q < AW'(2)) | (row_q < RW'(2)) | (row_q >= RW'(IH));
   end

   line_buffer #(.DW(DW), .IW(IW)) u_buf0 (
      .clk    (clk),
      .en_i   (wr_en),
      .addr_i (col_q),
      .wdat_i (in_data),
      .rdat_o (buf0_rd)
   );

   // Buffer 1 is fed from buffer 0's read port one cycle later, so its row-2 pixel lands in stage 3.
   line_buffer #(.DW(DW), .IW(IW)) u_buf1 (
      .clk    (clk),
      .en_i   (s1_en_q),
      .addr_i (s1_col_q),
      .wdat_i (buf0_rd),
      .rdat_o (buf1_rd)
   );

   // Only two window columns are stored; the third is the incoming column.
   always_comb begin
      part_d = SW'(mid_q[0]) + SW'(mid_q[1]) + SW'(buf0_rd)
             + SW'(bot_q[0]) + SW'(bot_q[1]) + SW'(s1_pix_q);
      sum_d  = s2_part_q + SW'(top_q[0]) + SW'(top_q[1]) + SW'(buf1_rd);
      out_data_d = '0;
      if (!s2_q.mask) begin
         out_data_d = DW'((PW'(sum_d) * PW'(MEAN_RECIP) + RND) >> MEAN_SHIFT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         s1_q         <= '0;
         s1_pix_q     <= '0;
         s1_col_q     <= '0;
         s1_en_q      <= 1'b0;
         mid_q        <= '0;
         bot_q        <= '0;
         s2_q         <= '0;
         s2_part_q    <= '0;
         s2_en_q      <= 1'b0;
         top_q        <= '0;
         out_vsync_q  <= 1'b0;
         out_dvalid_q <= 1'b0;
         out_data_q   <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         s1_q      <= s1_d;
         s1_pix_q  <= in_data;
         s1_col_q  <= col_q;
         s1_en_q   <= wr_en;
         if (s1_en_q) begin
            mid_q <= {buf0_rd, mid_q[1]};
            bot_q <= {s1_pix_q, bot_q[1]};
         end
         s2_q      <= s1_q;
         s2_part_q <= part_d;
         s2_en_q   <= s1_en_q;
         if (s2_en_q) begin
            top_q <= {buf1_rd, top_q[1]};
         end
         out_vsync_q  <= s2_q.vsync;
         out_dvalid_q <= s2_q.vld;
         out_data_q   <= out_data_d;
      end
   end

   assign out_vsync  = out_vsync_q;
   assign out_dvalid = out_dvalid_q;
   assign out_data   = out_data_q;

endmodule
